// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the baud divisor helper.
// Optional feature macro: UART_RX_PARITY_EN (adds the even-parity state).
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Rounded clocks-per-oversample-tick; never below one clock.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    int unsigned d;
    d = (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator; free-running divider shared by RX and TX.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Divider wraps DIV-1 -> 0 and emits a one-clock tick on the wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_cmd.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a
// one-byte valid/ready holding register and frame-error/overrun pulses.
// Optional feature macro: UART_RX_PARITY_EN.
module uart_rx_cmd
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [3:0] TICK_MID  = 4'(MID_TICK);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  logic       tick;
  logic       rx_meta;
  logic       rx_sync;
  logic       rx_prev;
  rx_state_t  state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       done;
`ifdef UART_RX_PARITY_EN
  logic       par_err;
`endif

  uart_baud_tick #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receive FSM: start validation, mid-bit data sampling, stop check.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            state    <= START;
            tick_cnt <= '0;
`ifdef UART_RX_PARITY_EN
            par_err  <= 1'b0;
`endif
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              state    <= rx_sync ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_sync, shreg[7:1]};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              par_err  <= rx_sync ^ (^shreg);
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (rx_sync) begin
                state <= IDLE;
`ifdef UART_RX_PARITY_EN
                // A parity failure with a good stop bit still ends in IDLE.
                if (par_err) frame_err <= 1'b1;
                else         done      <= 1'b1;
`else
                done <= 1'b1;
`endif
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register: load on completion unless full and not draining.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Self-checking bench for uart_rx_cmd: table vectors, randomized frames
// against a frame-level reference, and hand sequences for the corner cases.
module tb_uart_rx_cmd;

  localparam int unsigned CLK_HZ   = 14745600;
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned BIT_CLKS = 128;  // 16 ticks x 8 clocks per tick

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rxd   = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_q[$];
  int rd_ptr   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int wide_cnt = 0;
  int fe_base  = 0;
  int ov_base  = 0;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         exp_hs;
    int         exp_fe;
  } vec_t;

  vec_t vecs[5];

  uart_rx_cmd #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  // Observe consumer handshakes and error pulses away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      if (valid && ready) got_q.push_back(data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if ((frame_err && fe_prev) || (overrun && ov_prev)) wide_cnt++;
    end
    fe_prev = frame_err;
    ov_prev = overrun;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clks(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ par_flip;
    wait_clks(BIT_CLKS);
`endif
    rxd = stop;
    wait_clks(BIT_CLKS);
    rxd = 1'b1;
  endtask

  task automatic check_frame(input string name, input int exp_hs,
                             input logic [7:0] exp_b, input int exp_fe,
                             input int exp_ov);
    check({name, "_hs"}, got_q.size() - rd_ptr, exp_hs);
    if (exp_hs == 1 && got_q.size() > rd_ptr)
      check({name, "_data"}, {24'd0, got_q[rd_ptr]}, {24'd0, exp_b});
    rd_ptr = got_q.size();
    check({name, "_ferr"}, fe_cnt - fe_base, exp_fe);
    check({name, "_ovr"}, ov_cnt - ov_base, exp_ov);
    fe_base = fe_cnt;
    ov_base = ov_cnt;
  endtask

  initial begin
    logic [7:0] rb;
    logic       rstop;
    int         gap;

    vecs[0] = '{b: 8'h55, stop: 1'b1, exp_hs: 1, exp_fe: 0};
    vecs[1] = '{b: 8'hA5, stop: 1'b0, exp_hs: 0, exp_fe: 1};
    vecs[2] = '{b: 8'h00, stop: 1'b1, exp_hs: 1, exp_fe: 0};
    vecs[3] = '{b: 8'hFF, stop: 1'b1, exp_hs: 1, exp_fe: 0};
    vecs[4] = '{b: 8'hC3, stop: 1'b1, exp_hs: 1, exp_fe: 0};

    #2 reset = 1'b0;
    wait_clks(3);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_data", {24'd0, data}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    check("rst_ovr", {31'd0, overrun}, 0);
    reset = 1'b1;
    wait_clks(BIT_CLKS);

    // Table-driven frames with the consumer always ready.
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].b, vecs[i].stop);
      wait_clks(16);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_hs, vecs[i].b,
                  vecs[i].exp_fe, 0);
    end

    // Random bytes, random stop-bit faults and idle gaps.
    for (int i = 0; i < 8; i++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      gap   = $urandom_range(0, 3);
      send_frame(rb, rstop);
      wait_clks(gap * BIT_CLKS + 16);
      check_frame($sformatf("rand%0d", i), rstop ? 1 : 0, rb,
                  rstop ? 0 : 1, 0);
    end

    // Overrun: consumer stalled across two frames.
    ready = 1'b0;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    wait_clks(16);
    check("ovr_valid", {31'd0, valid}, 1);
    check("ovr_data", {24'd0, data}, 32'hA3);
    check_frame("ovr", 0, 8'h00, 0, 1);
    ready = 1'b1;
    wait_clks(2);
    check("ovr_drained", {31'd0, valid}, 0);
    check_frame("ovr_drain", 1, 8'hA3, 0, 0);

    // Framing error followed by a held-low line, then recovery.
    send_frame(8'h3C, 1'b0);
    rxd = 1'b0;
    wait_clks(3 * BIT_CLKS);
    rxd = 1'b1;
    wait_clks(BIT_CLKS);
    check("ferr_valid", {31'd0, valid}, 0);
    check_frame("ferr3c", 0, 8'h00, 1, 0);
    send_frame(8'h81, 1'b1);
    wait_clks(16);
    check_frame("after_ferr", 1, 8'h81, 0, 0);

    // Short low glitch must be rejected silently.
    rxd = 1'b0;
    wait_clks(32);
    rxd = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check_frame("glitch", 0, 8'h00, 0, 0);
    send_frame(8'h7E, 1'b1);
    wait_clks(16);
    check_frame("after_glitch", 1, 8'h7E, 0, 0);

    // Reset in the middle of a frame with a byte already held.
    ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    wait_clks(16);
    check("pre_rst_valid", {31'd0, valid}, 1);
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    rxd = 1'b1;
    wait_clks(4 * BIT_CLKS + BIT_CLKS / 2);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", {31'd0, valid}, 0);
    check("midrst_data", {24'd0, data}, 0);
    check("midrst_ferr", {31'd0, frame_err}, 0);
    check("midrst_ovr", {31'd0, overrun}, 0);
    wait_clks(20);
    reset = 1'b1;
    wait_clks(6 * BIT_CLKS);
    ready = 1'b1;
    wait_clks(4);
    check("post_rst_valid", {31'd0, valid}, 0);
    send_frame(8'h12, 1'b1);
    wait_clks(16);
    check_frame("after_rst", 1, 8'h12, 0, 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x01 needs a parity bit of 1.
    par_flip = 1'b1;
    send_frame(8'h01, 1'b1);
    wait_clks(16);
    check("par_bad_valid", {31'd0, valid}, 0);
    check_frame("par_bad", 0, 8'h00, 1, 0);
    par_flip = 1'b0;
    send_frame(8'h01, 1'b1);
    wait_clks(16);
    check_frame("par_good", 1, 8'h01, 0, 0);
`endif

    check("pulse_width", wide_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
